// File: rtl/fetch_queue.sv
// Fetch-to-decode decoupling queue: up to two instructions in, up to two out per cycle.
// Optional stall-cycle performance counter enabled by defining FETCH_QUEUE_PERF_EN.
module fetch_queue #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [ADDR_WIDTH-1:0]     in_addr_0,
    input  logic [ADDR_WIDTH-1:0]     in_addr_1,
    input  logic [DATA_WIDTH-1:0]     in_instr_0,
    input  logic [DATA_WIDTH-1:0]     in_instr_1,
    input  logic [1:0]                in_valid,
    input  logic                      in_predict_taken,
    input  logic [ADDR_WIDTH-1:0]     in_predict_target,
    output logic                      fetch_ready,
    output logic [ADDR_WIDTH-1:0]     out_addr_0,
    output logic [ADDR_WIDTH-1:0]     out_addr_1,
    output logic [DATA_WIDTH-1:0]     out_instr_0,
    output logic [DATA_WIDTH-1:0]     out_instr_1,
    output logic                      out_pred_taken_0,
    output logic                      out_pred_taken_1,
    output logic [ADDR_WIDTH-1:0]     out_pred_target_0,
    output logic [ADDR_WIDTH-1:0]     out_pred_target_1,
    output logic [1:0]                out_valid,
    input  logic [1:0]                deq_count,
`ifdef FETCH_QUEUE_PERF_EN
    output logic [31:0]               stall_cycles,
`endif
    output logic [$clog2(DEPTH):0]    count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]      r_head;
    logic [PTR_W-1:0]      r_tail;
    logic [CNT_W-1:0]      r_count;

    logic [ADDR_WIDTH-1:0] r_addr   [DEPTH];
    logic [DATA_WIDTH-1:0] r_instr  [DEPTH];
    logic                  r_taken  [DEPTH];
    logic [ADDR_WIDTH-1:0] r_target [DEPTH];

    logic                  w_ready;
    logic                  w_enq;
    logic [CNT_W-1:0]      w_enqNum;
    logic [1:0]            w_deqReq;
    logic [CNT_W-1:0]      w_deqNum;
    logic [PTR_W-1:0]      w_tail1;
    logic [PTR_W-1:0]      w_head1;

    logic                  w_wr0En;
    logic [ADDR_WIDTH-1:0] w_wr0Addr;
    logic [DATA_WIDTH-1:0] w_wr0Instr;
    logic                  w_wr0Taken;
    logic [ADDR_WIDTH-1:0] w_wr0Target;
    logic                  w_wr1En;

    logic                  w_has0;
    logic                  w_has1;

    // Readiness only looks at registered occupancy; a same-cycle dequeue earns no credit.
    assign w_ready = (r_count <= CNT_W'(DEPTH - 2));
    assign w_enq   = w_ready && (in_valid != 2'b00) && !flush;
    assign w_tail1 = r_tail + PTR_W'(1);
    assign w_head1 = r_head + PTR_W'(1);

    always_comb begin
        w_enqNum = '0;
        if (w_enq) begin
            w_enqNum = (in_valid == 2'b11) ? CNT_W'(2) : CNT_W'(1);
        end
    end

    always_comb begin
        w_deqReq = (deq_count == 2'b11) ? 2'b10 : deq_count;
        w_deqNum = '0;
        if (!flush) begin
            w_deqNum = (CNT_W'(w_deqReq) > r_count) ? r_count : CNT_W'(w_deqReq);
        end
    end

    // Port 0 always writes at tail with the lowest valid slot; port 1 only for a full pair.
    // The prediction rides on the highest-numbered valid slot of the pair.
    always_comb begin
        w_wr0En     = w_enq;
        w_wr1En     = w_enq && (in_valid == 2'b11);
        w_wr0Addr   = in_valid[0] ? in_addr_0  : in_addr_1;
        w_wr0Instr  = in_valid[0] ? in_instr_0 : in_instr_1;
        w_wr0Taken  = 1'b0;
        w_wr0Target = '0;
        if (in_valid != 2'b11) begin
            w_wr0Taken  = in_predict_taken;
            w_wr0Target = in_predict_target;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr0En) begin
            r_addr[r_tail]   <= w_wr0Addr;
            r_instr[r_tail]  <= w_wr0Instr;
            r_taken[r_tail]  <= w_wr0Taken;
            r_target[r_tail] <= w_wr0Target;
        end
        if (w_wr1En) begin
            r_addr[w_tail1]   <= in_addr_1;
            r_instr[w_tail1]  <= in_instr_1;
            r_taken[w_tail1]  <= in_predict_taken;
            r_target[w_tail1] <= in_predict_target;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + w_deqNum[PTR_W-1:0];
            r_tail  <= r_tail + w_enqNum[PTR_W-1:0];
            r_count <= r_count + w_enqNum - w_deqNum;
        end
    end

`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0] r_stallCycles;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stallCycles <= '0;
        end else if (!w_ready && (in_valid != 2'b00)) begin
            r_stallCycles <= r_stallCycles + 32'd1;
        end
    end

    assign stall_cycles = r_stallCycles;
`endif

    // Slots without a live entry read as zero so reset never exposes uninitialised storage.
    assign w_has0 = (r_count != '0);
    assign w_has1 = (r_count >= CNT_W'(2));

    assign fetch_ready       = w_ready;
    assign count             = r_count;
    assign out_valid         = {w_has1, w_has0};
    assign out_addr_0        = w_has0 ? r_addr[r_head]    : '0;
    assign out_instr_0       = w_has0 ? r_instr[r_head]   : '0;
    assign out_pred_taken_0  = w_has0 ? r_taken[r_head]   : 1'b0;
    assign out_pred_target_0 = w_has0 ? r_target[r_head]  : '0;
    assign out_addr_1        = w_has1 ? r_addr[w_head1]   : '0;
    assign out_instr_1       = w_has1 ? r_instr[w_head1]  : '0;
    assign out_pred_taken_1  = w_has1 ? r_taken[w_head1]  : 1'b0;
    assign out_pred_target_1 = w_has1 ? r_target[w_head1] : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: directed stimulus pushes expected entries,
// a negedge monitor compares the presented slots and pops what decode consumes.
module tb_fetch_queue;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic [AW-1:0] inAddr0 = '0;
    logic [AW-1:0] inAddr1 = '0;
    logic [DW-1:0] inInstr0 = '0;
    logic [DW-1:0] inInstr1 = '0;
    logic [1:0]    inValid = '0;
    logic          inTaken = 1'b0;
    logic [AW-1:0] inTarget = '0;
    logic [1:0]    deqCount = '0;
    logic          fetchReady;
    logic [AW-1:0] outAddr0, outAddr1, outTarget0, outTarget1;
    logic [DW-1:0] outInstr0, outInstr1;
    logic          outTaken0, outTaken1;
    logic [1:0]    outValid;
    logic [3:0]    count;
`ifdef FETCH_QUEUE_PERF_EN
    logic [31:0]   stallCycles;
`endif

    fetch_queue #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_addr_0(inAddr0), .in_addr_1(inAddr1),
        .in_instr_0(inInstr0), .in_instr_1(inInstr1),
        .in_valid(inValid), .in_predict_taken(inTaken), .in_predict_target(inTarget),
        .fetch_ready(fetchReady),
        .out_addr_0(outAddr0), .out_addr_1(outAddr1),
        .out_instr_0(outInstr0), .out_instr_1(outInstr1),
        .out_pred_taken_0(outTaken0), .out_pred_taken_1(outTaken1),
        .out_pred_target_0(outTarget0), .out_pred_target_1(outTarget1),
        .out_valid(outValid), .deq_count(deqCount),
`ifdef FETCH_QUEUE_PERF_EN
        .stall_cycles(stallCycles),
`endif
        .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] instr;
        logic        taken;
        logic [31:0] target;
    } entry_t;

    entry_t sc[$];
    int     mCount = 0;
    int     checks = 0;
    int     failures = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic entry_t mkEntry(input logic [31:0] a, input logic [31:0] i,
                                       input logic t, input logic [31:0] g);
        entry_t e;
        e.addr = a; e.instr = i; e.taken = t; e.target = g;
        return e;
    endfunction

    // Model-driven cycle: expected entries are queued when the model says the pair is accepted.
    task automatic applyStimulus(input logic [1:0] v, input logic [31:0] a0, input logic [31:0] i0,
                                 input logic [31:0] a1, input logic [31:0] i1, input logic tk,
                                 input logic [31:0] tg, input logic [1:0] deq, input logic fl);
        int enq;
        int eff;
        inValid = v; inAddr0 = a0; inInstr0 = i0; inAddr1 = a1; inInstr1 = i1;
        inTaken = tk; inTarget = tg; deqCount = deq; flush = fl;
        enq = 0;
        if (!fl && (mCount <= DEPTH - 2) && (v != 2'b00)) begin
            case (v)
                2'b11: begin
                    sc.push_back(mkEntry(a0, i0, 1'b0, 32'h0));
                    sc.push_back(mkEntry(a1, i1, tk, tg));
                    enq = 2;
                end
                2'b01: begin
                    sc.push_back(mkEntry(a0, i0, tk, tg));
                    enq = 1;
                end
                default: begin
                    sc.push_back(mkEntry(a1, i1, tk, tg));
                    enq = 1;
                end
            endcase
        end
        eff = fl ? 0 : ((int'(deq) > mCount) ? mCount : int'(deq));
        @(posedge clk);
        #1;
        if (fl) begin
            mCount = 0;
            sc.delete();
        end else begin
            mCount = mCount + enq - eff;
        end
        inValid = 2'b00; deqCount = 2'b00; flush = 1'b0; inTaken = 1'b0;
    endtask

    task automatic pushPair(input logic [31:0] base, input logic [1:0] deq);
        applyStimulus(2'b11, base, 32'hC000_0000 | base, base + 32'd4, 32'hC000_0000 | (base + 32'd4),
                      1'b0, 32'h0, deq, 1'b0);
    endtask

    task automatic idleCycle(input logic [1:0] deq);
        applyStimulus(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 32'h0, deq, 1'b0);
    endtask

    // Monitor: compares every presented slot against the scoreboard and retires consumed entries.
    always @(negedge clk) begin
        int     n;
        logic [1:0] expValid;
        entry_t e;
        expValid = (mCount == 0) ? 2'b00 : ((mCount == 1) ? 2'b01 : 2'b11);
        checkOutput("out_valid", 32'(outValid), 32'(expValid));
        checkOutput("count", 32'(count), 32'(mCount));
        checkOutput("fetch_ready", 32'(fetchReady), 32'((mCount <= DEPTH - 2) ? 1 : 0));
        if (sc.size() < mCount) begin
            checkOutput("scoreboard_depth", 32'(sc.size()), 32'(mCount));
        end else begin
            if (mCount >= 1) begin
                e = sc[0];
                checkOutput("slot0_addr", outAddr0, e.addr);
                checkOutput("slot0_instr", outInstr0, e.instr);
                checkOutput("slot0_taken", 32'(outTaken0), 32'(e.taken));
                checkOutput("slot0_target", outTarget0, e.target);
            end
            if (mCount >= 2) begin
                e = sc[1];
                checkOutput("slot1_addr", outAddr1, e.addr);
                checkOutput("slot1_instr", outInstr1, e.instr);
                checkOutput("slot1_taken", 32'(outTaken1), 32'(e.taken));
                checkOutput("slot1_target", outTarget1, e.target);
            end
            if (!flush && rst) begin
                n = (int'(deqCount) > mCount) ? mCount : int'(deqCount);
                repeat (n) void'(sc.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", 32'(outValid), 32'h0);
        checkOutput("reset_count", 32'(count), 32'h0);
        checkOutput("reset_fetch_ready", 32'(fetchReady), 32'h1);
        checkOutput("reset_addr0", outAddr0, 32'h0);
        checkOutput("reset_instr1", outInstr1, 32'h0);
        rst = 1'b1;

        // Single pair visible one cycle later
        pushPair(32'h100, 2'd0);
        checkOutput("pair_valid", 32'(outValid), 32'h3);
        checkOutput("pair_addr0", outAddr0, 32'h100);
        checkOutput("pair_addr1", outAddr1, 32'h104);
        checkOutput("pair_count", 32'(count), 32'h2);
        idleCycle(2'd2);

        // Slot-1-only with prediction, then over-dequeue
        applyStimulus(2'b10, 32'h200, 32'h11, 32'h204, 32'h22, 1'b1, 32'h300, 2'd0, 1'b0);
        checkOutput("s1_count", 32'(count), 32'h1);
        checkOutput("s1_addr0", outAddr0, 32'h204);
        checkOutput("s1_taken0", 32'(outTaken0), 32'h1);
        checkOutput("s1_target0", outTarget0, 32'h300);
        idleCycle(2'd2);
        checkOutput("overdeq_count", 32'(count), 32'h0);
        checkOutput("overdeq_valid", 32'(outValid), 32'h0);

        // Fill to full, including a predicted pair (taken lands on slot 1 only)
        pushPair(32'h600, 2'd0);
        applyStimulus(2'b11, 32'h608, 32'hC000_0608, 32'h60C, 32'hC000_060C, 1'b1, 32'h900, 2'd0, 1'b0);
        pushPair(32'h610, 2'd0);
        checkOutput("fill6_ready", 32'(fetchReady), 32'h1);
        pushPair(32'h618, 2'd0);
        checkOutput("full_count", 32'(count), 32'h8);
        checkOutput("full_ready", 32'(fetchReady), 32'h0);
        pushPair(32'h620, 2'd0);
        checkOutput("full_ignored_count", 32'(count), 32'h8);
        idleCycle(2'd2);
        checkOutput("after_deq_count", 32'(count), 32'h6);
        checkOutput("after_deq_ready", 32'(fetchReady), 32'h1);
        checkOutput("after_deq_addr0", outAddr0, 32'h608);
        applyStimulus(2'b01, 32'h700, 32'h77, 32'h0, 32'h0, 1'b1, 32'h777, 2'd0, 1'b0);
        checkOutput("count7_ready", 32'(fetchReady), 32'h0);
        pushPair(32'h800, 2'd0);
        checkOutput("count7_ignored", 32'(count), 32'h7);
        repeat (4) idleCycle(2'd2);
        checkOutput("drain_count", 32'(count), 32'h0);

        // Sustained enqueue/dequeue across pointer wrap
        for (int k = 0; k < 20; k++) begin
            pushPair(32'h1000 + 32'(8 * k), 2'd2);
            checkOutput("wrap_count", 32'(count), 32'h2);
        end
        idleCycle(2'd2);

        // Flush at count 5 with simultaneous enqueue and dequeue
        pushPair(32'h400, 2'd0);
        pushPair(32'h408, 2'd0);
        applyStimulus(2'b01, 32'h410, 32'h41, 32'h0, 32'h0, 1'b0, 32'h0, 2'd0, 1'b0);
        checkOutput("preflush_count", 32'(count), 32'h5);
        applyStimulus(2'b11, 32'hDEAD_0000, 32'h1, 32'hDEAD_0004, 32'h2, 1'b1, 32'hBEEF, 2'd2, 1'b1);
        checkOutput("flush_count", 32'(count), 32'h0);
        checkOutput("flush_valid", 32'(outValid), 32'h0);
        checkOutput("flush_ready", 32'(fetchReady), 32'h1);
        pushPair(32'h500, 2'd0);
        checkOutput("postflush_addr0", outAddr0, 32'h500);
        idleCycle(2'd2);

        // Asynchronous reset mid-operation
        pushPair(32'hA00, 2'd0);
        #2;
        rst = 1'b0;
        mCount = 0;
        sc.delete();
        #1;
        checkOutput("async_rst_count", 32'(count), 32'h0);
        checkOutput("async_rst_valid", 32'(outValid), 32'h0);
        checkOutput("async_rst_ready", 32'(fetchReady), 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        pushPair(32'hB00, 2'd0);
        checkOutput("post_rst_addr1", outAddr1, 32'hB04);
        idleCycle(2'd2);
        idleCycle(2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
